// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame controller: frame state encoding and
// command-byte field positions.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_CMD  = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_DONE = 2'd3
    } frame_state_t;

    localparam int BYTE_W = 8;
    localparam int RD_BIT = 7;  // command bit selecting read (1) or write (0)

endpackage

// File: rtl/spi_tx_shifter.sv
// MISO output shifter: loads a byte or shifts left on falling sclk, MSB drives miso.
// With neither load nor shift requested it empties, so miso returns to 0.
module spi_tx_shifter
    import spi_pkg::*;
(
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [BYTE_W-1:0] load_data,
    output logic              miso
);

    logic [BYTE_W-1:0] tx_sr;

    always_ff @(negedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr <= '0;
        end else if (load) begin
            tx_sr <= load_data;
        end else if (shift) begin
            tx_sr <= {tx_sr[BYTE_W-2:0], 1'b0};
        end else begin
            tx_sr <= '0;
        end
    end

    assign miso = tx_sr[BYTE_W-1];

endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI mode-0 slave frame controller: command byte then register write/read data.
// Define SPI_BURST_EN to allow multi-byte bursts with auto-incrementing address.
module spi_frame_ctrl
    import spi_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              wr_tgl,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              abort
);

`ifdef SPI_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    frame_state_t      state, state_nxt;
    logic [2:0]        bit_cnt;
    logic [6:0]        rx_sr;
    logic [7:0]        rx_byte;
    logic              byte_done;
    logic [ADDR_W-1:0] wr_ptr;
    logic              frame_rst_n;

    // NOTE: cs_n high acts as an asynchronous clear of the frame logic only;
    // the register-side outputs below survive the end of a frame.
    assign frame_rst_n = rst_n & ~cs_n;
    assign rx_byte     = {rx_sr, mosi};
    assign byte_done   = (bit_cnt == 3'd7);

    always_ff @(posedge sclk or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            state   <= ST_CMD;
            bit_cnt <= 3'd0;
            rx_sr   <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt + 3'd1;
            rx_sr   <= rx_byte[6:0];
        end
    end

    always_comb begin
        // NOTE: default assigned first so every path drives state_nxt (no latch).
        state_nxt = state;
        if (byte_done) begin
            unique case (state)
                ST_CMD:       state_nxt = rx_byte[RD_BIT] ? ST_RD : ST_WR;
                ST_WR, ST_RD: state_nxt = BURST_EN ? state : ST_DONE;
                default:      state_nxt = ST_DONE;
            endcase
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= '0;
            wr_data <= '0;
            wr_tgl  <= 1'b0;
            rd_addr <= '0;
            wr_ptr  <= '0;
        end else if (byte_done) begin
            unique case (state)
                ST_CMD: begin
                    if (rx_byte[RD_BIT]) rd_addr <= rx_byte[ADDR_W-1:0];
                    else                 wr_ptr  <= rx_byte[ADDR_W-1:0];
                end
                ST_WR: begin
                    wr_addr <= wr_ptr;
                    wr_data <= rx_byte;
                    wr_tgl  <= ~wr_tgl;
                    if (BURST_EN) wr_ptr <= wr_ptr + ADDR_W'(1);
                end
                ST_RD: begin
                    if (BURST_EN) rd_addr <= rd_addr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Sampled before the frame clear lands, so a mid-byte cs_n rise is caught.
    always_ff @(posedge cs_n or negedge rst_n) begin
        if (!rst_n) begin
            abort <= 1'b0;
        end else if (bit_cnt != 3'd0) begin
            abort <= 1'b1;
        end
    end

    spi_tx_shifter u_tx_shifter (
        .sclk      (sclk),
        .rst_n     (frame_rst_n),
        .load      ((state == ST_RD) && (bit_cnt == 3'd0)),
        .shift     ((state == ST_RD) && (bit_cnt != 3'd0)),
        .load_data (rd_data),
        .miso      (miso)
    );

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Self-checking bench for spi_frame_ctrl: directed frames then random frames,
// checked against a byte-level reference model and a register-file model.
module tb_spi_frame_ctrl;

    localparam int ADDR_W = 7;
    localparam int NREG   = 1 << ADDR_W;
`ifdef SPI_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic              sclk = 1'b0;
    logic              rst_n;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_tgl;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              abort;

    logic [7:0] regs [NREG];
    assign rd_data = regs[rd_addr];

    spi_frame_ctrl #(.ADDR_W(ADDR_W)) dut (
        .sclk    (sclk),
        .rst_n   (rst_n),
        .cs_n    (cs_n),
        .mosi    (mosi),
        .miso    (miso),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_tgl  (wr_tgl),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .abort   (abort)
    );

    always #5 sclk = ~sclk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state
    logic [ADDR_W-1:0] m_wr_addr, m_rd_addr;
    logic [7:0]        m_wr_data;
    logic              m_tgl, m_abort;
    logic              exp_miso[$];
    logic              got_miso[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, " wr_addr"}, 32'(wr_addr), 32'(m_wr_addr));
        check({tag, " wr_data"}, 32'(wr_data), 32'(m_wr_data));
        check({tag, " wr_tgl"},  32'(wr_tgl),  32'(m_tgl));
        check({tag, " rd_addr"}, 32'(rd_addr), 32'(m_rd_addr));
        check({tag, " abort"},   32'(abort),   32'(m_abort));
        check({tag, " miso"},    32'(miso),    32'(0));
    endtask

    task automatic model_reset();
        m_wr_addr = '0;
        m_rd_addr = '0;
        m_wr_data = '0;
        m_tgl     = 1'b0;
        m_abort   = 1'b0;
    endtask

    // Frame-level model: full bytes are bits/8; a trailing partial byte only sets abort.
    task automatic model_frame(input logic [7:0] b[$], input int nbits);
        int                nfull;
        int                nwr;
        logic [7:0]        cmd;
        logic [7:0]        v;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] idx;
        exp_miso.delete();
        for (int i = 0; i < nbits; i++) exp_miso.push_back(1'b0);
        nfull = nbits / 8;
        if (nbits % 8 != 0) m_abort = 1'b1;
        if (nfull == 0) return;
        cmd = b[0];
        a   = cmd[ADDR_W-1:0];
        if (cmd[7]) begin
            m_rd_addr = BURST ? a + ADDR_W'(nfull - 1) : a;
            for (int i = 8; i < nbits; i++) begin
                int k;
                k = (i - 8) / 8;
                if (BURST || k == 0) begin
                    idx = a + ADDR_W'(k);
                    v   = regs[idx];
                    exp_miso[i] = v[7 - (i % 8)];
                end
            end
        end else begin
            nwr = nfull - 1;
            if (!BURST && nwr > 1) nwr = 1;
            for (int k = 0; k < nwr; k++) begin
                m_wr_addr = a + ADDR_W'(k);
                m_wr_data = b[1 + k];
                m_tgl     = ~m_tgl;
            end
        end
    endtask

    // Master side: mosi changes 1 ns after falling sclk, miso sampled 2 ns later.
    task automatic run_frame(input string tag, input logic [7:0] b[$], input int nbits);
        logic [7:0] cur;
        model_frame(b, nbits);
        got_miso.delete();
        @(negedge sclk); #1;
        cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            cur  = b[i / 8];
            mosi = cur[7 - (i % 8)];
            #2;
            got_miso.push_back(miso);
            check($sformatf("%s miso bit%0d", tag, i), 32'(miso), 32'(exp_miso[i]));
            @(negedge sclk); #1;
        end
        cs_n = 1'b1;
        mosi = 1'b0;
        #1;
        check_outputs(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, required finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] rx;

        rst_n = 1'b0;
        cs_n  = 1'b1;
        mosi  = 1'b0;
        for (int i = 0; i < NREG; i++) regs[i] = 8'($urandom);
        model_reset();
        #12;
        check_outputs("reset");
        rst_n = 1'b1;

        // Plain write 0x05 <- 0xA5
        q = {8'h05, 8'hA5};
        run_frame("wr05", q, 16);
        check("wr05 addr const", 32'(wr_addr), 32'h05);
        check("wr05 data const", 32'(wr_data), 32'hA5);
        check("wr05 tgl const",  32'(wr_tgl),  32'h1);

        // Read address 3 holding 0x3C
        regs[3] = 8'h3C;
        q = {8'h83, 8'h00};
        run_frame("rd83", q, 16);
        rx = '0;
        for (int i = 8; i < 16; i++) rx = {rx[6:0], got_miso[i]};
        check("rd83 addr const", 32'(rd_addr), 32'h03);
        check("rd83 byte const", 32'(rx),      32'h3C);

        // Frame cut after 5 data bits, then a clean write
        q = {8'h10, 8'hFF};
        run_frame("abort", q, 13);
        check("abort flag const", 32'(abort),  32'h1);
        check("abort tgl const",  32'(wr_tgl), 32'h1);
        q = {8'h01, 8'h7E};
        run_frame("wr01", q, 16);
        check("wr01 addr const",  32'(wr_addr), 32'h01);
        check("wr01 data const",  32'(wr_data), 32'h7E);
        check("wr01 abort const", 32'(abort),   32'h1);

        // Reset mid-command with no sclk edge in between
        @(negedge sclk); #1;
        cs_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            @(negedge sclk); #1;
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_mid");
        cs_n = 1'b1;
        mosi = 1'b0;
        #1;
        rst_n = 1'b1;

        // Three-byte frame: burst writes two bytes, single mode ignores the third
        q = {8'h7F, 8'h11, 8'h22};
        run_frame("wr7f", q, 24);
        check("wr7f addr const", 32'(wr_addr), BURST ? 32'h00 : 32'h7F);
        check("wr7f data const", 32'(wr_data), BURST ? 32'h22 : 32'h11);
        check("wr7f tgl const",  32'(wr_tgl),  BURST ? 32'h0  : 32'h1);

        // Random frames, some cut short
        for (int r = 0; r < 40; r++) begin
            int nb;
            int nbits;
            q.delete();
            nb = int'($urandom_range(1, 3));
            for (int j = 0; j < nb; j++) q.push_back(8'($urandom));
            nbits = nb * 8;
            if ($urandom_range(0, 4) == 0) nbits -= int'($urandom_range(1, 7));
            if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, NREG - 1)] = 8'($urandom);
            run_frame($sformatf("rand%0d", r), q, nbits);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_frame_ctrl.md
SPI_FRAME_CTRL -- requirements
Module: spi_frame_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, meaning register address width taken from the low bits of the command byte.
REQ-002 SHALL have port sclk  in  1  SPI clock; the only clock of the block.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: cs_n  in  1  chip select, active low; mosi  in  1  serial data in; miso  out  1  serial data out.
REQ-005 SHALL have ports: wr_addr  out  ADDR_W  write address; wr_data  out  8  write data; wr_tgl  out  1  toggles once per completed write byte.
REQ-006 SHALL have ports: rd_addr  out  ADDR_W  read address; rd_data  in  8  register value for rd_addr, combinational on the consumer side.
REQ-007 SHALL have port abort  out  1  sticky flag: a frame ended mid-byte.

Function
REQ-008 SHALL use SPI mode 0, MSB first: mosi sampled on rising sclk; miso updated on falling sclk.
REQ-009 SHALL hold the frame FSM in CMD with bit counter 0 while cs_n is high, as an asynchronous clear; wr_addr, wr_data, wr_tgl, rd_addr and abort are not cleared by cs_n.
REQ-010 SHALL use a 3-bit bit counter that wraps 7->0 on every rising sclk with cs_n low; the byte completes on the rising edge where the counter is 7.
REQ-011 SHALL decode the command byte as bit7 = 1 read, 0 write, and bits[ADDR_W-1:0] as the address.
REQ-012 SHALL sequence states CMD -> WR (write) or CMD -> RD (read); from WR or RD, byte completion goes to DONE; DONE ignores mosi until cs_n goes high.
REQ-013 SHALL, on the command-byte completion edge, load rd_addr with the address for a read, and latch the address internally for a write.
REQ-014 SHALL, on WR byte completion, update wr_addr and wr_data together with the address and the received byte, and invert wr_tgl on that same edge.
REQ-015 SHALL, on the first falling sclk after a read command completes, load the output shifter from rd_data and drive its bit7 on miso; each later falling edge in RD shifts left by one.
REQ-016 SHALL drive miso 0 in CMD, WR and DONE.
REQ-017 SHALL set abort when cs_n rises with the bit counter non-zero; abort clears only on rst_n.
REQ-018 SHALL discard an incomplete byte: no wr_tgl change and no rd_addr change.

Reset
REQ-019 SHALL, on rst_n low, reset state to CMD, bit counter to 0, miso to 0, wr_addr/wr_data/rd_addr to 0, wr_tgl to 0 and abort to 0, independent of sclk.
REQ-020 SHALL give reset priority over cs_n and sclk; reset asserted mid-frame loses the frame without changing wr_tgl.

Configuration
REQ-021 SHALL, with SPI_BURST_EN defined, return from WR/RD byte completion to the same state with the address incremented modulo 2^ADDR_W; a write toggles wr_tgl per byte; a read updates rd_addr on the completion edge and reloads the shifter on the next falling edge.
REQ-022 SHALL, without SPI_BURST_EN, behave as REQ-012: one data byte per frame, then DONE.

Structure
REQ-023 SHALL place the state encoding (CMD, WR, RD, DONE) and the read-bit position constant in a shared package, spi_pkg.
REQ-024 SHALL implement the miso output shifter as sub-module spi_tx_shifter (falling-edge load/shift, async reset).

Verification
REQ-025 SHALL cover: frame 0x05,0xA5 -> wr_addr=0x05, wr_data=0xA5, wr_tgl 0->1, miso 0 throughout.
REQ-026 SHALL cover: frame 0x83 with rd_data model holding 0x3C at address 3 -> rd_addr=0x03 and miso bits 0,0,1,1,1,1,0,0 on the data byte.
REQ-027 SHALL cover: cs_n raised after 5 bits of a data byte -> abort=1, wr_tgl unchanged; the next full write 0x01,0x7E succeeds.
REQ-028 SHALL cover: rst_n pulsed low mid-command -> all outputs at reset values immediately, with no sclk edge required.
REQ-029 SHALL cover, with SPI_BURST_EN: frame 0x7F,0x11,0x22 -> writes (0x7F,0x11) then (0x00,0x22), and wr_tgl toggles twice.
REQ-030 SHALL cover, without SPI_BURST_EN: the same frame -> only (0x7F,0x11) is written, and the third byte is ignored.
